// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST frame loader.
package mnist_pkg;
  localparam int N_PIX = 784;
  localparam int IMG_W = 28;
  localparam int CNT_W = $clog2(N_PIX);
  localparam logic [3:0] ERR_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    RESULT
  } state_t;
endpackage

// File: rtl/mnist_frame_assembler.sv
// Binarizes the pixel stream, shifts it into the image register and tracks
// frame position, early pix_last and a missing final pix_last.
module mnist_frame_assembler
  import mnist_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             clear,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic [N_PIX-1:0] image,
  output logic [CNT_W-1:0] count,
  output logic             frame_done,
  output logic             early_last,
  output logic             err_flag
);
  logic beat;
  logic pix_bit;
  logic at_end;

  assign beat       = pix_valid & load_en;
  assign pix_bit    = (pix_data >= PIX_W'(THRESH));
  assign at_end     = (count == CNT_W'(N_PIX - 1));
  assign frame_done = beat & at_end;
  assign early_last = beat & pix_last & ~at_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      image    <= '0;
      count    <= '0;
      err_flag <= 1'b0;
    end else begin
      // First pixel ends up in the MSB once the frame is complete.
      if (beat) begin
        image <= {image[N_PIX-2:0], pix_bit};
        count <= count + CNT_W'(1);
      end
      if (clear) begin
        count    <= '0;
        err_flag <= 1'b0;
      end else if (frame_done && !pix_last) begin
        err_flag <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/mnist_frame_loader.sv
// Feeds binarized frames to the MNIST model, waits for its classification
// and returns the digit (or an error) on a valid/ready result handshake.
module mnist_frame_loader
  import mnist_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int THRESH  = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [N_PIX-1:0] image_out,
  output logic             start,
  input  logic             model_valid,
  input  logic [3:0]       model_digit,
  output logic [3:0]       res_digit,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic             run_q;
  logic             valid_q;
  logic             model_edge;
  logic             tmo_hit;
  logic [TMO_W-1:0] tmo;
  logic [CNT_W-1:0] count;
  logic             frame_done, early_last, err_flag;
  logic             clear, ld_res, err_nx;
  logic [3:0]       digit_nx;

  mnist_frame_assembler #(
    .PIX_W (PIX_W),
    .THRESH(THRESH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .load_en   (pix_ready),
    .clear     (clear),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_last  (pix_last),
    .image     (image_out),
    .count     (count),
    .frame_done(frame_done),
    .early_last(early_last),
    .err_flag  (err_flag)
  );

  // run_q holds pix_ready low for the first cycle after reset release.
  assign pix_ready  = run_q && (state == LOAD);
  assign busy       = (state != LOAD) || (count != '0);
  assign model_edge = model_valid & ~valid_q;
  assign tmo_hit    = (tmo == TMO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      run_q   <= 1'b1;
      valid_q <= model_valid;
    end
  end

  always_comb begin
    state_nx  = state;
    ld_res    = 1'b0;
    digit_nx  = ERR_DIGIT;
    err_nx    = 1'b1;
    clear     = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      LOAD: begin
        if (early_last) begin
          state_nx = RESULT;
          ld_res   = 1'b1;
        end else if (frame_done) begin
          state_nx = START;
        end
      end
      START: begin
        start    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (model_edge) begin
          state_nx = RESULT;
          ld_res   = 1'b1;
          digit_nx = model_digit;
          err_nx   = err_flag | (model_digit > 4'd9);
        end else if (tmo_hit) begin
          state_nx = RESULT;
          ld_res   = 1'b1;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = LOAD;
          clear    = 1'b1;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo       <= '0;
      res_digit <= '0;
      res_err   <= 1'b0;
    end else begin
      tmo <= (state == WAIT && !tmo_hit) ? tmo + TMO_W'(1) : '0;
      if (ld_res) begin
        res_digit <= digit_nx;
        res_err   <= err_nx;
      end
    end
  end
endmodule

// File: tb/tb_mnist_frame_loader.sv
// Self-checking bench for mnist_frame_loader with a programmable model stub
// and a pixel-array reference model of the expected image and result.
module tb_mnist_frame_loader;
  import mnist_pkg::*;

  localparam int TIMEOUT = 4096;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic [7:0]       pix_data  = '0;
  logic             pix_valid = 1'b0;
  logic             pix_last  = 1'b0;
  logic             res_ready = 1'b0;
  logic             pix_ready, start, model_valid, res_err, res_valid, busy;
  logic [N_PIX-1:0] image_out;
  logic [3:0]       model_digit, res_digit;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;
  byte unsigned frame_pix [N_PIX];

  logic       stub_en      = 1'b1;
  logic       stub_hold    = 1'b0;
  logic       stub_busy    = 1'b0;
  logic       stub_v       = 1'b0;
  int         stub_lat     = 20;
  int         stub_cnt     = 0;
  logic [3:0] stub_digit   = 4'd0;
  logic [3:0] stub_digit_q = 4'd0;

  typedef struct {
    int         digit;
    int         last_at;
    int         lat;
    int         gap;
    logic [3:0] exp_digit;
    logic       exp_err;
  } res_vec_t;

  typedef struct {
    byte unsigned pix;
    logic         exp_bit;
  } thr_vec_t;

  res_vec_t rv [7];
  thr_vec_t tv [8];

  assign model_valid = stub_v;
  assign model_digit = stub_digit_q;

  always #5 clk = ~clk;

  mnist_frame_loader #(
    .PIX_W  (8),
    .THRESH (128),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .image_out  (image_out),
    .start      (start),
    .model_valid(model_valid),
    .model_digit(model_digit),
    .res_digit  (res_digit),
    .res_err    (res_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  // Model stub: answers stub_lat cycles after start; optionally keeps valid high.
  always @(posedge clk) begin
    if (start) begin
      start_cnt <= start_cnt + 1;
      stub_cnt  <= stub_lat;
      stub_busy <= stub_en;
      if (stub_en) stub_v <= 1'b0;
    end else if (stub_busy) begin
      if (stub_cnt <= 1) begin
        stub_v       <= 1'b1;
        stub_digit_q <= stub_digit;
        stub_busy    <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end else if (!stub_hold) begin
      stub_v <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [N_PIX-1:0] exp);
    int first;
    checks++;
    if (image_out !== exp) begin
      errors++;
      first = 0;
      for (int i = N_PIX - 1; i >= 0; i--)
        if (image_out[i] !== exp[i]) begin
          first = i;
          break;
        end
      $display("FAIL %s: image_out bit %0d got %b, expected %b", name, first,
               image_out[first], exp[first]);
    end
  endtask

  // Reference: pixel i of the frame lands at bit N_PIX-1-i, set when >= 128.
  function automatic logic [N_PIX-1:0] ref_image();
    logic [N_PIX-1:0] img;
    for (int i = 0; i < N_PIX; i++) img[N_PIX-1-i] = (frame_pix[i] >= 8'd128);
    return img;
  endfunction

  function automatic bit pat7(int r, int c);
    return (r >= 4 && r <= 6 && c >= 6 && c <= 21) ||
           (r >= 7 && r <= 23 && c >= 20 - (r - 7) / 2 && c <= 21 - (r - 7) / 2);
  endfunction

  function automatic bit pat2(int r, int c);
    return (r >= 4 && r <= 5 && c >= 6 && c <= 21) ||
           (r >= 6 && r <= 12 && c >= 20 && c <= 21) ||
           (r >= 13 && r <= 14 && c >= 6 && c <= 21) ||
           (r >= 15 && r <= 21 && c >= 6 && c <= 7) ||
           (r >= 22 && r <= 23 && c >= 6 && c <= 21);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N_PIX; i++) frame_pix[i] = 8'($urandom_range(255));
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap, output int sent);
    int   budget;
    logic took;
    sent   = 0;
    budget = 0;
    while (sent < n && budget < 20 * N_PIX) begin
      pix_valid = (int'($urandom_range(99)) >= gap);
      pix_data  = frame_pix[sent];
      pix_last  = (sent == last_at);
      took      = pix_valid & pix_ready;
      tick();
      if (took) sent++;
      budget++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    pix_data  = '0;
  endtask

  task automatic wait_result(input int max_wait, output int waited);
    waited = 0;
    while (!res_valid && waited < max_wait) begin
      tick();
      waited++;
    end
  endtask

  task automatic run_frame(input string tag, input int last_at, input int gap,
                           input logic [3:0] exp_digit, input logic exp_err,
                           input int max_wait, input int stall, output int waited);
    int               n, sent, s0;
    logic             full, stable;
    logic [N_PIX-1:0] exp_img;
    full    = (last_at < 0) || (last_at >= N_PIX - 1);
    n       = full ? N_PIX : last_at + 1;
    exp_img = ref_image();
    s0      = start_cnt;
    send_frame(n, last_at, gap, sent);
    check({tag, " beats"}, 32'(sent), 32'(n));
    if (full) begin
      check({tag, " start latency"}, 32'(start), 32'd1);
      check_img({tag, " image"}, exp_img);
    end else begin
      check({tag, " abort"}, 32'({start, res_valid}), 32'b01);
    end
    wait_result(max_wait, waited);
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    check({tag, " res_digit"}, 32'(res_digit), 32'(exp_digit));
    check({tag, " res_err"}, 32'(res_err), 32'(exp_err));
    check({tag, " start pulses"}, 32'(start_cnt - s0), full ? 32'd1 : 32'd0);
    if (stall > 0) begin
      stable    = 1'b1;
      pix_valid = 1'b1;
      pix_data  = 8'hFF;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (!res_valid || pix_ready || !busy || res_digit !== exp_digit || res_err !== exp_err)
          stable = 1'b0;
      end
      pix_valid = 1'b0;
      check({tag, " stall stable"}, 32'(stable), 32'd1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, " back to load"}, 32'({res_valid, busy, pix_ready}), 32'b001);
    if (full) check_img({tag, " image held"}, exp_img);
  endtask

  initial begin
    int w;

    rv[0] = '{7,  783, 20, 30, 4'd7,  1'b0};
    rv[1] = '{0,  100, 5,  20, 4'hF,  1'b1};
    rv[2] = '{9,  783, 60, 10, 4'd9,  1'b0};
    rv[3] = '{12, 783, 1,  25, 4'hC,  1'b1};
    rv[4] = '{3,  -1,  5,  15, 4'd3,  1'b1};
    rv[5] = '{5,  0,   5,  0,  4'hF,  1'b1};
    rv[6] = '{1,  782, 5,  35, 4'hF,  1'b1};

    tv[0] = '{8'd0,   1'b0};
    tv[1] = '{8'd1,   1'b0};
    tv[2] = '{8'd126, 1'b0};
    tv[3] = '{8'd127, 1'b0};
    tv[4] = '{8'd128, 1'b1};
    tv[5] = '{8'd129, 1'b1};
    tv[6] = '{8'd254, 1'b1};
    tv[7] = '{8'd255, 1'b1};

    repeat (3) tick();
    check("reset outputs", 32'({pix_ready, start, res_valid, res_err, busy}), 32'd0);
    check("reset res_digit", 32'(res_digit), 32'd0);
    check_img("reset image", '0);
    rst = 1'b1;
    tick();
    check("ready after release", 32'({pix_ready, busy}), 32'b10);

    // Digit 7 as 0x00/0xFF beats, no gaps.
    for (int r = 0; r < IMG_W; r++)
      for (int c = 0; c < IMG_W; c++)
        frame_pix[r * IMG_W + c] = pat7(r, c) ? 8'hFF : 8'h00;
    stub_lat   = 20;
    stub_digit = 4'd7;
    run_frame("digit7", 783, 0, 4'd7, 1'b0, 200, 0, w);

    // 127/128 alternating, dense and with random valid gaps.
    for (int i = 0; i < N_PIX; i++) frame_pix[i] = (i % 2 == 1) ? 8'd128 : 8'd127;
    stub_digit = 4'd1;
    run_frame("alt dense", 783, 0, 4'd1, 1'b0, 200, 0, w);
    check("alt msb pair", 32'(image_out[N_PIX-1 -: 2]), 32'b01);
    run_frame("alt gaps", 783, 50, 4'd1, 1'b0, 200, 0, w);

    // Threshold boundary table.
    for (int i = 0; i < N_PIX; i++) frame_pix[i] = tv[i % 8].pix;
    stub_digit = 4'd8;
    run_frame("thresh", 783, 10, 4'd8, 1'b0, 200, 0, w);
    for (int r = 0; r < 8; r++)
      check($sformatf("thresh pix %0d", tv[r].pix), 32'(image_out[N_PIX-1-r]), 32'(tv[r].exp_bit));

    // Result table with random pixels.
    for (int k = 0; k < 7; k++) begin
      fill_random();
      stub_lat   = rv[k].lat;
      stub_digit = 4'(rv[k].digit);
      run_frame($sformatf("vec%0d", k), rv[k].last_at, rv[k].gap, rv[k].exp_digit,
                rv[k].exp_err, rv[k].lat + 50, 0, w);
    end

    // Model valid left high, then never re-raised: timeout path.
    fill_random();
    stub_hold  = 1'b1;
    stub_lat   = 8;
    stub_digit = 4'd4;
    run_frame("hold", 783, 20, 4'd4, 1'b0, 100, 0, w);
    fill_random();
    stub_en = 1'b0;
    run_frame("timeout", 783, 20, 4'hF, 1'b1, TIMEOUT + 300, 0, w);
    check("timeout not early", 32'(w >= TIMEOUT), 32'd1);
    check("timeout not late", 32'(w <= TIMEOUT + 8), 32'd1);
    stub_en   = 1'b1;
    stub_hold = 1'b0;

    // Result held with res_ready low for 50 cycles.
    fill_random();
    stub_lat   = 10;
    stub_digit = 4'd6;
    run_frame("stall", 783, 20, 4'd6, 1'b0, 100, 50, w);

    // Reset in the middle of a frame.
    fill_random();
    send_frame(400, -1, 20, w);
    check("partial beats", 32'(w), 32'd400);
    check("partial busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst outputs", 32'({pix_ready, start, res_valid, res_err, busy}), 32'd0);
    check("midrst res_digit", 32'(res_digit), 32'd0);
    check_img("midrst image", '0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst ready", 32'(pix_ready), 32'd1);
    for (int r = 0; r < IMG_W; r++)
      for (int c = 0; c < IMG_W; c++)
        frame_pix[r * IMG_W + c] = pat2(r, c) ? 8'hFF : 8'h00;
    stub_lat   = 15;
    stub_digit = 4'd2;
    run_frame("digit2", 783, 15, 4'd2, 1'b0, 200, 0, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
